rv32_hazard_ctrl: RTL and testbench

RV32_HAZARD_CTRL -- requirements
Module: rv32_hazard_ctrl

---
 rtl/rv32_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_rv32_hazard_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_hazard_ctrl.sv
// RV32 hazard unit: forwarding, load-use/structural/dependency stalls, redirect flush.
// Define HAZARD_SCOREBOARD_EN for a per-register busy scoreboard on multi-cycle ops.
module rv32_hazard_ctrl #(
  parameter int FETCH_STAGES = 2,
  parameter int MC_DEPTH     = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [4:0] rs1_d_i,
  input  logic [4:0] rs2_d_i,
  input  logic [4:0] rd_d_i,
  input  logic       mc_op_d_i,
  input  logic [4:0] rs1_e_i,
  input  logic [4:0] rs2_e_i,
  input  logic [4:0] rd_e_i,
  input  logic       result_src_e_b0_i,
  input  logic       pc_src_e_i,
  input  logic       mc_issue_e_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  input  logic       mc_done_i,
  input  logic [4:0] mc_rd_i,
  output logic       stall_f_o,
  output logic       stall_d_o,
  output logic       flush_d_o,
  output logic       flush_e_o,
  output logic [1:0] forward_ae_o,
  output logic [1:0] forward_be_o
);

  localparam int CW = $clog2(MC_DEPTH + 1);
  localparam int FW = (FETCH_STAGES > 1) ? $clog2(FETCH_STAGES) : 1;
  localparam logic [FW-1:0] FL_LOAD = FW'(FETCH_STAGES - 1);
  localparam logic [CW:0] MC_LIM = (CW+1)'(MC_DEPTH);

  logic [CW-1:0] cnt_q;
  logic [CW:0]   cnt_sum;
  logic [FW-1:0] fl_q;
  logic          mc_dec;
  logic          load_stall;
  logic          struct_stall;
  logic          dep_stall;
  logic          hz_stall;
  logic          hz_live;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != 5'd0 && reg_write_m_i && rs == rd_m_i)
      sel = 2'b10;
    else if (rs != 5'd0 && reg_write_w_i && rs == rd_w_i)
      sel = 2'b01;
    return sel;
  endfunction

  assign forward_ae_o = fwd_sel(rs1_e_i);
  assign forward_be_o = fwd_sel(rs2_e_i);

  assign load_stall = result_src_e_b0_i
                    & (rd_e_i != 5'd0)
                    & ((rs1_d_i == rd_e_i)
                     | (rs2_d_i == rd_e_i));

  // A done with nothing outstanding is spurious and dropped.
  assign mc_dec = mc_done_i & (cnt_q != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      cnt_q <= '0;
    else if (mc_issue_e_i && !mc_dec)
      cnt_q <= cnt_q + 1'b1;
    else if (!mc_issue_e_i && mc_dec)
      cnt_q <= cnt_q - 1'b1;
  end

  assign cnt_sum = {1'b0, cnt_q}
                 + {{CW{1'b0}}, mc_issue_e_i};
  assign struct_stall = mc_op_d_i
                      & (cnt_sum >= MC_LIM);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      fl_q <= '0;
    else if (pc_src_e_i)
      fl_q <= FL_LOAD;
    else if (fl_q != '0)
      fl_q <= fl_q - 1'b1;
  end

`ifdef HAZARD_SCOREBOARD_EN
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [31:0] busy_v;
  logic [31:0] set_v;
  logic [31:0] clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (mc_issue_e_i && rd_e_i != 5'd0)
      set_v[rd_e_i] = 1'b1;
    if (mc_done_i)
      clr_v[mc_rd_i] = 1'b1;
    busy_v    = busy_q | set_v;
    busy_d    = (busy_q & ~clr_v) | set_v;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign dep_stall = busy_v[rs1_d_i]
                   | busy_v[rs2_d_i]
                   | busy_v[rd_d_i];
`else
  logic unused_sb;
  assign unused_sb = ^{rd_d_i, mc_rd_i};
  // No per-register tracking: decode waits for every outstanding op.
  assign dep_stall = mc_issue_e_i | (cnt_q != '0);
`endif

  assign flush_d_o = pc_src_e_i | (fl_q != '0);
  assign hz_stall  = load_stall | struct_stall | dep_stall;
  assign hz_live   = hz_stall & ~flush_d_o;
  assign stall_f_o = hz_live;
  assign stall_d_o = hz_live;
  assign flush_e_o = pc_src_e_i | hz_live;

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Directed bench for rv32_hazard_ctrl (FETCH_STAGES=3, MC_DEPTH=2).
// Scoreboard checks run only when HAZARD_SCOREBOARD_EN is defined.
module tb_rv32_hazard_ctrl;

`ifdef HAZARD_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [4:0] rs1_d_i, rs2_d_i, rd_d_i;
  logic       mc_op_d_i;
  logic [4:0] rs1_e_i, rs2_e_i, rd_e_i;
  logic       result_src_e_b0_i;
  logic       pc_src_e_i;
  logic       mc_issue_e_i;
  logic [4:0] rd_m_i, rd_w_i;
  logic       reg_write_m_i, reg_write_w_i;
  logic       mc_done_i;
  logic [4:0] mc_rd_i;
  logic       stall_f_o, stall_d_o;
  logic       flush_d_o, flush_e_o;
  logic [1:0] forward_ae_o, forward_be_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic dep_exp;

  rv32_hazard_ctrl #(
    .FETCH_STAGES(3),
    .MC_DEPTH(2)
  ) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .rs1_d_i(rs1_d_i),
    .rs2_d_i(rs2_d_i),
    .rd_d_i(rd_d_i),
    .mc_op_d_i(mc_op_d_i),
    .rs1_e_i(rs1_e_i),
    .rs2_e_i(rs2_e_i),
    .rd_e_i(rd_e_i),
    .result_src_e_b0_i(result_src_e_b0_i),
    .pc_src_e_i(pc_src_e_i),
    .mc_issue_e_i(mc_issue_e_i),
    .rd_m_i(rd_m_i),
    .rd_w_i(rd_w_i),
    .reg_write_m_i(reg_write_m_i),
    .reg_write_w_i(reg_write_w_i),
    .mc_done_i(mc_done_i),
    .mc_rd_i(mc_rd_i),
    .stall_f_o(stall_f_o),
    .stall_d_o(stall_d_o),
    .flush_d_o(flush_d_o),
    .flush_e_o(flush_e_o),
    .forward_ae_o(forward_ae_o),
    .forward_be_o(forward_be_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic clr_in();
    rs1_d_i = '0; rs2_d_i = '0; rd_d_i = '0;
    mc_op_d_i = 0;
    rs1_e_i = '0; rs2_e_i = '0; rd_e_i = '0;
    result_src_e_b0_i = 0;
    pc_src_e_i = 0;
    mc_issue_e_i = 0;
    rd_m_i = '0; rd_w_i = '0;
    reg_write_m_i = 0; reg_write_w_i = 0;
    mc_done_i = 0;
    mc_rd_i = '0;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    dep_exp = SB ? 1'b0 : 1'b1;
    clr_in();
    rst_n_i = 0;
    #2;
    chk("rst_stall_f", 32'(stall_f_o), 0);
    chk("rst_stall_d", 32'(stall_d_o), 0);
    chk("rst_flush_d", 32'(flush_d_o), 0);
    chk("rst_flush_e", 32'(flush_e_o), 0);
    chk("rst_fwd_a", 32'(forward_ae_o), 0);
    chk("rst_fwd_b", 32'(forward_be_o), 0);
    cyc();
    rst_n_i = 1;

    // forwarding
    cyc();
    rd_m_i = 5; rd_w_i = 5;
    reg_write_m_i = 1; reg_write_w_i = 1;
    rs1_e_i = 5; #1;
    chk("fwd_a_m_wins", 32'(forward_ae_o), 2);
    rs1_e_i = 0; #1;
    chk("fwd_a_x0", 32'(forward_ae_o), 0);
    rs1_e_i = 5; rd_m_i = 6; #1;
    chk("fwd_a_w", 32'(forward_ae_o), 1);
    rd_m_i = 5; reg_write_m_i = 0; #1;
    chk("fwd_a_m_off", 32'(forward_ae_o), 1);
    reg_write_w_i = 0; #1;
    chk("fwd_a_none", 32'(forward_ae_o), 0);
    reg_write_m_i = 1; rs2_e_i = 5; #1;
    chk("fwd_b_m", 32'(forward_be_o), 2);
    rs2_e_i = 3; rd_w_i = 3;
    reg_write_w_i = 1; #1;
    chk("fwd_b_w", 32'(forward_be_o), 1);
    chk("fwd_a_indep", 32'(forward_ae_o), 2);
    clr_in();

    // load-use
    cyc();
    result_src_e_b0_i = 1; rd_e_i = 7;
    rs2_d_i = 7; #1;
    chk("ld_stall_f", 32'(stall_f_o), 1);
    chk("ld_stall_d", 32'(stall_d_o), 1);
    chk("ld_flush_e", 32'(flush_e_o), 1);
    chk("ld_flush_d", 32'(flush_d_o), 0);
    cyc();
    result_src_e_b0_i = 0; rd_e_i = 0; #1;
    chk("ld_release", 32'(stall_d_o), 0);
    chk("ld_rel_fe", 32'(flush_e_o), 0);
    result_src_e_b0_i = 1; rs2_d_i = 0; #1;
    chk("ld_rd0", 32'(stall_d_o), 0);
    rd_e_i = 7; rs1_d_i = 7; #1;
    chk("ld_rs1", 32'(stall_f_o), 1);
    rs1_d_i = 8; #1;
    chk("ld_nomatch", 32'(stall_f_o), 0);
    clr_in();

    // redirect flush, single pulse
    cyc();
    pc_src_e_i = 1; #1;
    chk("fl0_d", 32'(flush_d_o), 1);
    chk("fl0_e", 32'(flush_e_o), 1);
    cyc();
    pc_src_e_i = 0;
    result_src_e_b0_i = 1; rd_e_i = 7;
    rs2_d_i = 7; #1;
    chk("fl1_d", 32'(flush_d_o), 1);
    chk("fl1_no_stall", 32'(stall_f_o), 0);
    chk("fl1_no_fe", 32'(flush_e_o), 0);
    clr_in();
    cyc();
    chk("fl2_d", 32'(flush_d_o), 1);
    cyc();
    chk("fl3_d", 32'(flush_d_o), 0);

    // redirect flush, re-pulse at cycle 2
    pc_src_e_i = 1;
    cyc();
    pc_src_e_i = 0; #1;
    chk("rf1_d", 32'(flush_d_o), 1);
    cyc();
    pc_src_e_i = 1; #1;
    chk("rf2_d", 32'(flush_d_o), 1);
    cyc();
    pc_src_e_i = 0; #1;
    chk("rf3_d", 32'(flush_d_o), 1);
    cyc();
    chk("rf4_d", 32'(flush_d_o), 1);
    cyc();
    chk("rf5_d", 32'(flush_d_o), 0);

    // reset mid-flush
    pc_src_e_i = 1;
    cyc();
    pc_src_e_i = 0; #1;
    rst_n_i = 0; #1;
    chk("rst_fl", 32'(flush_d_o), 0);
    cyc();
    rst_n_i = 1;

    // spurious done with nothing outstanding
    cyc();
    mc_done_i = 1;
    cyc();
    mc_done_i = 0; mc_op_d_i = 1; #1;
    chk("no_underflow", 32'(stall_d_o), 0);
    clr_in();

    // structural stall
    cyc();
    mc_issue_e_i = 1; #1;
    chk("mc_iss1", 32'(stall_d_o), 32'(dep_exp));
    cyc();
    mc_op_d_i = 1; #1;
    chk("mc_iss2_str", 32'(stall_d_o), 1);
    cyc();
    mc_issue_e_i = 0; #1;
    chk("mc_full", 32'(stall_f_o), 1);
    chk("mc_full_fe", 32'(flush_e_o), 1);
    mc_op_d_i = 0; #1;
    chk("mc_full_noop", 32'(stall_d_o), 32'(dep_exp));
    cyc();
    mc_issue_e_i = 1; mc_done_i = 1;
    mc_op_d_i = 1; #1;
    chk("mc_iss_done", 32'(stall_d_o), 1);
    cyc();
    mc_issue_e_i = 0; mc_done_i = 0; #1;
    chk("mc_hold2", 32'(stall_d_o), 1);
    cyc();
    mc_done_i = 1; #1;
    chk("mc_done_cyc", 32'(stall_d_o), 1);
    cyc();
    mc_done_i = 0; #1;
    chk("mc_after_done", 32'(stall_d_o), 32'(dep_exp));
    cyc();
    mc_issue_e_i = 1;
    cyc();
    mc_issue_e_i = 0; #1;
    chk("mc_refill", 32'(stall_d_o), 1);
    rst_n_i = 0; #1;
    chk("mc_rst_now", 32'(stall_d_o), 0);
    cyc();
    rst_n_i = 1; #1;
    chk("mc_rst_after", 32'(stall_d_o), 0);
    clr_in();

`ifdef HAZARD_SCOREBOARD_EN
    cyc();
    mc_issue_e_i = 1; rd_e_i = 9;
    rs1_d_i = 9; #1;
    chk("sb_issue_cyc", 32'(stall_d_o), 1);
    cyc();
    mc_issue_e_i = 0; rd_e_i = 0; #1;
    chk("sb_busy", 32'(stall_d_o), 1);
    rs1_d_i = 10; #1;
    chk("sb_other", 32'(stall_d_o), 0);
    rs1_d_i = 9;
    cyc();
    pc_src_e_i = 1; #1;
    chk("sb_redir", 32'(stall_d_o), 0);
    chk("sb_redir_fe", 32'(flush_e_o), 1);
    cyc();
    pc_src_e_i = 0; #1;
    chk("sb_fl1", 32'(stall_d_o), 0);
    cyc();
    cyc();
    chk("sb_fl_end", 32'(stall_d_o), 1);
    cyc();
    mc_done_i = 1; mc_rd_i = 9; #1;
    chk("sb_done_cyc", 32'(stall_d_o), 1);
    cyc();
    mc_done_i = 0; #1;
    chk("sb_release", 32'(stall_d_o), 0);
    clr_in();
    cyc();
    mc_issue_e_i = 1; rd_e_i = 4;
    mc_done_i = 1; mc_rd_i = 4;
    cyc();
    clr_in();
    rs2_d_i = 4; #1;
    chk("sb_set_wins", 32'(stall_d_o), 1);
    mc_done_i = 1; mc_rd_i = 4;
    cyc();
    clr_in();
    rd_d_i = 4; #1;
    chk("sb_clr4", 32'(stall_d_o), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
